// File: rtl/vend_dispense_ctrl.sv
// Actuator controller behind the coin vending FSM: queues dispense/change pulses,
// drives motor and ejector, confirms via sensors. Optional stats counters: VEND_STATS_EN.
module vend_dispense_ctrl #(
    parameter int MOTOR_TO = 1000,
    parameter int EJECT_W  = 4,
    parameter int COIN_TO  = 200,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend_req,
    input  logic             change_req,
    input  logic             drop_sense,
    input  logic             coin_sense,
    input  logic             fault_clr,
    output logic             motor_on,
    output logic             eject,
    output logic             busy,
    output logic             vend_done,
    output logic             change_done,
    output logic             fault,
    output logic             ovf,
`ifdef VEND_STATS_EN
    output logic [15:0]      vend_cnt,
    output logic [15:0]      change_cnt,
`endif
    output logic [CNT_W-1:0] vend_pend,
    output logic [CNT_W-1:0] change_pend
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND,
        ST_EJECT,
        ST_EJECT_WAIT,
        ST_FAULT
    } state_t;

    // One shared timer serves whichever phase is active.
    localparam int TMR_LIM = (MOTOR_TO > COIN_TO)
                           ? ((MOTOR_TO > EJECT_W) ? MOTOR_TO : EJECT_W)
                           : ((COIN_TO  > EJECT_W) ? COIN_TO  : EJECT_W);
    localparam int TMR_W = (TMR_LIM < 2) ? 1 : $clog2(TMR_LIM);
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             coin_seen;
    logic             vend_take;
    logic             change_take;
    logic             vend_lost;
    logic             change_lost;

    always_comb begin
        vend_take   = (state == ST_IDLE) && (vend_pend != '0);
        change_take = (state == ST_IDLE) && (vend_pend == '0) && (change_pend != '0);
        vend_lost   = vend_req   && !vend_take   && (vend_pend   == CNT_FULL);
        change_lost = change_req && !change_take && (change_pend == CNT_FULL);
    end

    assign motor_on = (state == ST_VEND);
    assign eject    = (state == ST_EJECT);
    assign busy     = (state != ST_IDLE);
    assign fault    = (state == ST_FAULT);

    // NOTE: reset is synchronous, so rst stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            coin_seen   <= 1'b0;
            vend_pend   <= '0;
            change_pend <= '0;
            vend_done   <= 1'b0;
            change_done <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            vend_done   <= 1'b0;
            change_done <= 1'b0;

            if (vend_req && !vend_take && !vend_lost)
                vend_pend <= vend_pend + CNT_W'(1);
            else if (!vend_req && vend_take)
                vend_pend <= vend_pend - CNT_W'(1);

            if (change_req && !change_take && !change_lost)
                change_pend <= change_pend + CNT_W'(1);
            else if (!change_req && change_take)
                change_pend <= change_pend - CNT_W'(1);

            // A request lost in the same cycle as fault_clr keeps ovf set.
            ovf <= (ovf && !fault_clr) || vend_lost || change_lost;

            case (state)
                ST_IDLE: begin
                    if (vend_take) begin
                        state <= ST_VEND;
                        timer <= '0;
                    end else if (change_take) begin
                        state     <= ST_EJECT;
                        timer     <= '0;
                        coin_seen <= 1'b0;
                    end
                end
                ST_VEND: begin
                    if (drop_sense) begin
                        state     <= ST_IDLE;
                        vend_done <= 1'b1;
                    end else if (timer == TMR_W'(MOTOR_TO - 1)) begin
                        state <= ST_FAULT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_EJECT: begin
                    if (coin_sense)
                        coin_seen <= 1'b1;
                    if (timer == TMR_W'(EJECT_W - 1)) begin
                        state <= ST_EJECT_WAIT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_EJECT_WAIT: begin
                    if (coin_seen || coin_sense) begin
                        state       <= ST_IDLE;
                        change_done <= 1'b1;
                        coin_seen   <= 1'b0;
                    end else if (timer == TMR_W'(COIN_TO - 1)) begin
                        state <= ST_FAULT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (fault_clr)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VEND_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            vend_cnt   <= '0;
            change_cnt <= '0;
        end else begin
            vend_cnt   <= vend_cnt   + 16'(vend_done);
            change_cnt <= change_cnt + 16'(change_done);
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a job-level reference model.
module tb_vend_dispense_ctrl;

    localparam int MOTOR_TO = 16;
    localparam int EJECT_W  = 4;
    localparam int COIN_TO  = 8;
    localparam int CNT_W    = 2;
    localparam int MAXQ     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, vend_req, change_req, drop_sense, coin_sense, fault_clr;
    logic motor_on, eject, busy, vend_done, change_done, fault, ovf;
    logic [CNT_W-1:0] vend_pend, change_pend;
`ifdef VEND_STATS_EN
    logic [15:0] vend_cnt, change_cnt;
`endif

    always #5 clk = ~clk;

    vend_dispense_ctrl #(
        .MOTOR_TO(MOTOR_TO), .EJECT_W(EJECT_W), .COIN_TO(COIN_TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .vend_req(vend_req), .change_req(change_req),
        .drop_sense(drop_sense), .coin_sense(coin_sense), .fault_clr(fault_clr),
        .motor_on(motor_on), .eject(eject), .busy(busy),
        .vend_done(vend_done), .change_done(change_done),
        .fault(fault), .ovf(ovf),
`ifdef VEND_STATS_EN
        .vend_cnt(vend_cnt), .change_cnt(change_cnt),
`endif
        .vend_pend(vend_pend), .change_pend(change_pend)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one job at a time, elapsed cycles counted across the whole job.
    typedef enum {J_NONE, J_VEND, J_CHG, J_FAULT} job_t;
    job_t m_job;
    int   m_el, m_vq, m_cq, m_vcnt, m_ccnt;
    bit   m_coin, m_ovf, m_vdone, m_cdone;

    task automatic model_step(input bit vr, cr, ds, cs, fc, rn);
        bit tv, tc, lv, lc;
        if (!rn) begin
            m_job = J_NONE; m_el = 0; m_vq = 0; m_cq = 0; m_vcnt = 0; m_ccnt = 0;
            m_coin = 0; m_ovf = 0; m_vdone = 0; m_cdone = 0;
            return;
        end
        m_vcnt = (m_vcnt + int'(m_vdone)) % 65536;
        m_ccnt = (m_ccnt + int'(m_cdone)) % 65536;
        tv = (m_job == J_NONE) && (m_vq > 0);
        tc = (m_job == J_NONE) && (m_vq == 0) && (m_cq > 0);
        lv = vr && !tv && (m_vq == MAXQ);
        lc = cr && !tc && (m_cq == MAXQ);
        m_vq  = m_vq + int'(vr && !lv) - int'(tv);
        m_cq  = m_cq + int'(cr && !lc) - int'(tc);
        m_ovf = (m_ovf && !fc) || lv || lc;
        m_vdone = 0;
        m_cdone = 0;
        case (m_job)
            J_NONE: begin
                if (tv) begin m_job = J_VEND; m_el = 0; end
                else if (tc) begin m_job = J_CHG; m_el = 0; m_coin = 0; end
            end
            J_VEND: begin
                if (ds) begin m_job = J_NONE; m_vdone = 1; end
                else if (m_el == MOTOR_TO - 1) m_job = J_FAULT;
                else m_el++;
            end
            J_CHG: begin
                if (m_el < EJECT_W) begin
                    if (cs) m_coin = 1;
                    m_el++;
                end else if (m_coin || cs) begin
                    m_job = J_NONE; m_cdone = 1;
                end else if (m_el == EJECT_W + COIN_TO - 1) begin
                    m_job = J_FAULT;
                end else begin
                    m_el++;
                end
            end
            J_FAULT: if (fc) m_job = J_NONE;
            default: m_job = J_NONE;
        endcase
    endtask

    task automatic compare_all();
        check("motor_on",    motor_on,    32'(m_job == J_VEND));
        check("eject",       eject,       32'(m_job == J_CHG && m_el < EJECT_W));
        check("busy",        busy,        32'(m_job != J_NONE));
        check("fault",       fault,       32'(m_job == J_FAULT));
        check("vend_done",   vend_done,   32'(m_vdone));
        check("change_done", change_done, 32'(m_cdone));
        check("ovf",         ovf,         32'(m_ovf));
        check("vend_pend",   vend_pend,   m_vq);
        check("change_pend", change_pend, m_cq);
`ifdef VEND_STATS_EN
        check("vend_cnt",    vend_cnt,    m_vcnt);
        check("change_cnt",  change_cnt,  m_ccnt);
`endif
    endtask

    int mon_motor, mon_eject, mon_vd, mon_cd, cyc_n, ej_fall, flt_rise;
    logic prev_eject = 1'b0, prev_fault = 1'b0;

    task automatic clr_mon();
        mon_motor = 0; mon_eject = 0; mon_vd = 0; mon_cd = 0;
        ej_fall = -1; flt_rise = -1;
    endtask

    task automatic cyc(input bit vr = 0, cr = 0, ds = 0, cs = 0, fc = 0, rn = 1);
        @(negedge clk);
        vend_req = vr; change_req = cr; drop_sense = ds; coin_sense = cs;
        fault_clr = fc; rst = rn;
        @(posedge clk);
        model_step(vr, cr, ds, cs, fc, rn);
        #1;
        compare_all();
        cyc_n++;
        if (motor_on)    mon_motor++;
        if (eject)       mon_eject++;
        if (vend_done)   mon_vd++;
        if (change_done) mon_cd++;
        if (prev_eject && !eject) ej_fall = cyc_n;
        if (!prev_fault && fault) flt_rise = cyc_n;
        prev_eject = eject;
        prev_fault = fault;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        int sp;
        rst = 1'b0; vend_req = 1'b0; change_req = 1'b0;
        drop_sense = 1'b0; coin_sense = 1'b0; fault_clr = 1'b0;
        cyc_n = 0;
        clr_mon();

        repeat (3) cyc(.rn(0));
        check("reset_busy", busy, 0);

        // Single vend, drop sensed on the 5th motor cycle.
        clr_mon();
        cyc(.vr(1)); idle(5); cyc(.ds(1)); idle(3);
        check("A_motor_cycles", mon_motor, 5);
        check("A_vend_done_pulses", mon_vd, 1);
        check("A_busy", busy, 0);
        check("A_vend_pend", vend_pend, 0);

        // Simultaneous requests: vend first, then change.
        clr_mon();
        cyc(.vr(1), .cr(1));
        check("B_vend_pend", vend_pend, 1);
        check("B_change_pend", change_pend, 1);
        idle(2); cyc(.ds(1));
        check("B_no_eject_during_vend", mon_eject, 0);
        idle(6); cyc(.cs(1)); idle(3);
        check("B_eject_cycles", mon_eject, 4);
        check("B_change_done_pulses", mon_cd, 1);
        check("B_fault", fault, 0);

        // Motor timeout, request captured during FAULT, then cleared.
        clr_mon();
        cyc(.vr(1)); idle(18);
        check("C_motor_cycles", mon_motor, 16);
        check("C_fault", fault, 1);
        check("C_motor_off", motor_on, 0);
        cyc(.vr(1));
        check("C_pend_in_fault", vend_pend, 1);
        cyc(.fc(1));
        check("C_idle_after_clr", busy, 0);
        cyc();
        check("C_queued_starts", motor_on, 1);
        cyc(.ds(1)); idle(2);

        // Overflow while VEND is stalled.
        clr_mon();
        cyc(.vr(1)); cyc();
        repeat (4) cyc(.vr(1));
        check("D_vend_pend_sat", vend_pend, 3);
        check("D_ovf_set", ovf, 1);
        cyc(.fc(1));
        check("D_ovf_cleared", ovf, 0);
        check("D_still_vending", motor_on, 1);
        repeat (12) cyc(.ds(1));
        check("D_drained", vend_pend, 0);
        check("D_vend_done_pulses", mon_vd, 4);

        // Coin timeout.
        clr_mon();
        cyc(.cr(1)); idle(16);
        check("E_eject_cycles", mon_eject, 4);
        check("E_fault_delay", flt_rise - ej_fall, 8);
        check("E_fault", fault, 1);
        cyc(.fc(1));
        check("E_fault_clr", fault, 0);

        // Coin sensed during the eject pulse.
        clr_mon();
        cyc(.cr(1)); cyc(); cyc(.cs(1)); idle(6);
        check("E2_change_done_pulses", mon_cd, 1);
        check("E2_no_fault", fault, 0);
        check("E2_eject_cycles", mon_eject, 4);

        // Reset mid-VEND discards the queue.
        clr_mon();
        cyc(.vr(1)); cyc(.vr(1)); cyc(.vr(1));
        check("F_motor_before", motor_on, 1);
        check("F_pend_before", vend_pend, 2);
        cyc(.rn(0));
        check("F_motor_off", motor_on, 0);
        check("F_pend_cleared", vend_pend, 0);
`ifdef VEND_STATS_EN
        check("F_vend_cnt", vend_cnt, 0);
`endif
        cyc();
        check("F_stays_idle", busy, 0);

        // Randomized traffic, alternating responsive and sluggish sensors.
        for (int ph = 0; ph < 6; ph++) begin
            sp = (ph % 2 == 0) ? 25 : 3;
            repeat (600) begin
                cyc(.vr($urandom_range(99) < 12),
                    .cr($urandom_range(99) < 10),
                    .ds($urandom_range(99) < sp),
                    .cs($urandom_range(99) < sp),
                    .fc($urandom_range(99) < 4),
                    .rn($urandom_range(999) >= 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
